fetch_queue: RTL

- Instruction-fetch front end sitting directly upstream of the single-cycle ARM core's decode/execute.
- Generates sequential word addresses into the synchronous instruction memory and buffers the returned 32-bit instructions, tagged with their PCs, in a small FIFO.
- Presents the FIFO head to the core over a valid/ready handshake.
- A redirect (taken branch, B.LT, CBZ) flushes the buffer, kills any in-flight fetch and restarts fetching at the target.

---
 rtl/fetch_queue.sv | 92 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches and buffers the returned
// instructions with their PCs in a small circular queue presented over valid/ready.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_W-1:0]     out_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_instr_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem    [DEPTH];

    logic [CNT_W-1:0]  w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;

    // An in-flight request already owns a slot, so it counts towards occupancy.
    assign w_occupancy = r_count + CNT_W'(r_inflight);
    assign w_issue     = !reset && !redirect && (w_occupancy < CNT_W'(DEPTH));
    assign w_push      = r_inflight && !redirect;
    assign w_pop       = out_valid && out_ready;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;
    assign out_valid = !reset && (r_count != '0);
    assign out_instr = r_instr_mem[r_rptr];
    assign out_pc    = r_pc_mem[r_rptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            // Flush wins over any same-cycle push, pop or response.
            r_fetch_pc <= redirect_pc & ~ADDR_W'(3);
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                r_inflight <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_issue) r_req_pc <= r_fetch_pc;
        if (w_push) begin
            r_instr_mem[r_wptr] <= imem_rdata;
            r_pc_mem[r_wptr]    <= r_req_pc;
        end
    end

endmodule
